fsub_norm_rnd: RTL and testbench

- Back end of the FSUB datapath: consumes the raw 34-bit mantissa sum/difference plus pre-normalization exponent and sign, and produces a packed IEEE-754 single-precision result with status flags.
- Internally counts leading zeros, left-normalizes, adjusts the exponent, rounds to nearest-even and packs the result.
- 3-stage valid/ready pipeline sitting between the FSUB add/sub stage and the fsincos result mux.

---
 rtl/fsub_pkg.sv | 37 +++
 rtl/fsub_norm_rnd_if.sv | 37 +++
 rtl/fsub_lzc34.sv | 44 ++++
 rtl/fsub_norm_rnd.sv | 161 ++++++++++++++++
 tb/tb_fsub_norm_rnd.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fsub_pkg.sv
// ---------------------------------------------------------------------------
// fsub_pkg
// Shared constants and types for the FSUB normalize/round back end.
//   - Exponent/fraction widths and bias of IEEE-754 single precision.
//   - Bit positions inside the 34-bit raw mantissa coming from add/sub:
//     bit 33 carry-out, bit 32 nominal hidden one, bits 8:0 the
//     guard/sticky extension produced by operand alignment.
//   - Packed single-precision result type.
// ---------------------------------------------------------------------------
package fsub_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    // Largest biased exponent; it encodes infinity.
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam int MANT_W         = 34;
    localparam int MANT_CARRY     = 33;
    localparam int MANT_HIDDEN    = 32;
    localparam int MANT_GUARD     = 9;
    localparam int MANT_STICKY_HI = 8;
    localparam int MANT_STICKY_LO = 0;

    // Leading-zero count range is 0..34, so 6 bits.
    localparam int LZ_W = 6;
    // Signed working exponent: two extra bits hold negatives and the
    // overflow past 255 after a rounding carry.
    localparam int E_W  = EXP_W + 2;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } sp_float_t;

endpackage

// File: rtl/fsub_norm_rnd_if.sv
// ---------------------------------------------------------------------------
// fsub_norm_rnd_if
// Handshake and data bundle around the FSUB normalize/round block.
//   Input side : i_valid, o_ready, i_sign, i_exp, i_mant
//   Output side: o_valid, i_ready, o_result, o_zero, o_ovf, o_unf, o_inexact
// Signal names keep the block's point of view: i_* flow into the block,
// o_* flow out of it.
//   master : the environment (upstream producer + downstream consumer)
//   slave  : the normalize/round block itself
// ---------------------------------------------------------------------------
interface fsub_norm_rnd_if;

    logic                        i_valid;
    logic                        o_ready;
    logic                        i_sign;
    logic [fsub_pkg::EXP_W-1:0]  i_exp;
    logic [fsub_pkg::MANT_W-1:0] i_mant;

    logic                        o_valid;
    logic                        i_ready;
    logic [31:0]                 o_result;
    logic                        o_zero;
    logic                        o_ovf;
    logic                        o_unf;
    logic                        o_inexact;

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_ready,
        input  o_ready, o_valid, o_result, o_zero, o_ovf, o_unf, o_inexact
    );

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_ready,
        output o_ready, o_valid, o_result, o_zero, o_ovf, o_unf, o_inexact
    );

endinterface

// File: rtl/fsub_lzc34.sv
// ---------------------------------------------------------------------------
// fsub_lzc34
// Registered-input leading-zero counter for the 34-bit raw mantissa.
//   clk : clock
//   en  : load enable for the input register (pipeline advance)
//   d   : mantissa to register
//   q   : registered mantissa
//   lz  : leading zeros of q counted from bit 33, 0..34 (34 for q == 0)
// ---------------------------------------------------------------------------
module fsub_lzc34
    import fsub_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [MANT_W-1:0] d,
    output logic [MANT_W-1:0] q,
    output logic [LZ_W-1:0]   lz
);

    // Input register; holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

    // Priority scan from the carry bit downward. An all-zero word is
    // detected explicitly rather than relying on the scan falling through.
    always_comb begin
        logic found;
        lz    = '0;
        found = 1'b0;
        for (int i = MANT_CARRY; i >= 0; i--) begin
            if (!found && q[i]) begin
                lz    = LZ_W'(MANT_CARRY - i);
                found = 1'b1;
            end
        end
        if (q == '0) begin
            lz = LZ_W'(MANT_W);
        end
    end

endmodule

// File: rtl/fsub_norm_rnd.sv
// ---------------------------------------------------------------------------
// fsub_norm_rnd
// FSUB back end: normalizes the raw add/sub magnitude, adjusts the
// exponent, rounds to nearest-even and packs an IEEE-754 single.
// Three-stage valid/ready pipeline with a single global enable.
//   i_clk : clock
//   i_rst : synchronous active-high reset (clears all stage valids)
//   bus   : slave side of fsub_norm_rnd_if
//           in : i_valid, i_sign, i_exp, i_mant, i_ready
//           out: o_ready, o_valid, o_result, o_zero, o_ovf, o_unf, o_inexact
// ---------------------------------------------------------------------------
module fsub_norm_rnd
    import fsub_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    fsub_norm_rnd_if.slave bus
);

    logic en;

    logic                    v1, v2, v3;

    logic                    sign1;
    logic [EXP_W-1:0]        exp1;
    logic [MANT_W-1:0]       mant1;
    logic [LZ_W-1:0]         lz1;

    logic [MANT_HIDDEN:0]    nm_s1;
    logic signed [E_W-1:0]   e_s1;

    logic                    sign2;
    logic [MANT_HIDDEN:0]    nm2;
    logic signed [E_W-1:0]   e2;
    logic                    zero2;

    logic [FRAC_W-1:0]       frac_s2;
    logic                    guard_s2;
    logic                    sticky_s2;
    logic                    rnd_up_s2;
    logic                    carry_s2;
    logic [FRAC_W-1:0]       frac_rnd_s2;
    logic signed [E_W-1:0]   e_rnd_s2;
    sp_float_t               res_s2;
    logic                    zero_s2, ovf_s2, unf_s2, inex_s2;

    sp_float_t               res3;
    logic                    zero3, ovf3, unf3, inex3;

    localparam logic signed [E_W-1:0] E_MAX_S = E_W'(EXP_MAX);

    // A stage only advances when the output slot is free or being drained;
    // with no internal skid buffering every register shares this enable.
    assign en          = ~v3 | bus.i_ready;
    assign bus.o_ready = en;

    // Valid chain. Bubbles travel through as v = 0 so beat order and
    // spacing are preserved exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (en) begin
            v1 <= bus.i_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // S1: capture sign and exponent; the mantissa register lives inside
    // the leading-zero counter.
    always_ff @(posedge i_clk) begin
        if (en) begin
            sign1 <= bus.i_sign;
            exp1  <= bus.i_exp;
        end
    end

    fsub_lzc34 u_lzc (
        .clk (i_clk),
        .en  (en),
        .d   (bus.i_mant),
        .q   (mant1),
        .lz  (lz1)
    );

    // Left-normalize so the leading one lands on bit 33; that bit is
    // implicit afterwards, so only bits 32:0 are kept. The exponent gains
    // one for the carry position and loses one per shifted zero.
    always_comb begin
        nm_s1 = mant1[MANT_HIDDEN:0] << lz1;
        e_s1  = $signed({2'b00, exp1}) + $signed(E_W'(1))
              - $signed({{(E_W-LZ_W){1'b0}}, lz1});
    end

    // S2 register.
    always_ff @(posedge i_clk) begin
        if (en) begin
            sign2 <= sign1;
            nm2   <= nm_s1;
            e2    <= e_s1;
            zero2 <= (mant1 == '0);
        end
    end

    // Round to nearest-even and classify. Underflow is judged on the
    // normalized exponent, overflow after a possible rounding carry, and an
    // exact zero outranks both because its exponent is meaningless.
    always_comb begin
        frac_s2   = nm2[MANT_HIDDEN:MANT_GUARD+1];
        guard_s2  = nm2[MANT_GUARD];
        sticky_s2 = |nm2[MANT_STICKY_HI:MANT_STICKY_LO];
        rnd_up_s2 = guard_s2 & (sticky_s2 | frac_s2[0]);
        {carry_s2, frac_rnd_s2} = {1'b0, frac_s2} + {{FRAC_W{1'b0}}, rnd_up_s2};
        e_rnd_s2  = e2 + $signed({{(E_W-1){1'b0}}, carry_s2});

        res_s2  = '0;
        zero_s2 = 1'b0;
        ovf_s2  = 1'b0;
        unf_s2  = 1'b0;
        inex_s2 = 1'b0;
        if (zero2) begin
            zero_s2 = 1'b1;
        end else if (e2 <= $signed(E_W'(0))) begin
            res_s2.sign = sign2;
            unf_s2      = 1'b1;
            inex_s2     = 1'b1;
        end else if (e_rnd_s2 >= E_MAX_S) begin
            res_s2.sign = sign2;
            res_s2.exp  = '1;
            ovf_s2      = 1'b1;
            inex_s2     = 1'b1;
        end else begin
            res_s2.sign = sign2;
            res_s2.exp  = e_rnd_s2[EXP_W-1:0];
            res_s2.frac = frac_rnd_s2;
            inex_s2     = guard_s2 | sticky_s2;
        end
    end

    // S3 register: packed result and flags.
    always_ff @(posedge i_clk) begin
        if (en) begin
            res3  <= res_s2;
            zero3 <= zero_s2;
            ovf3  <= ovf_s2;
            unf3  <= unf_s2;
            inex3 <= inex_s2;
        end
    end

    // Outputs read as zero whenever no beat is presented.
    assign bus.o_valid   = v3;
    assign bus.o_result  = v3 ? res3 : 32'h0;
    assign bus.o_zero    = v3 & zero3;
    assign bus.o_ovf     = v3 & ovf3;
    assign bus.o_unf     = v3 & unf3;
    assign bus.o_inexact = v3 & inex3;

endmodule

// File: tb/tb_fsub_norm_rnd.sv
// ---------------------------------------------------------------------------
// tb_fsub_norm_rnd
// Directed bench for fsub_norm_rnd: reset state, normalization, rounding,
// zero/overflow/underflow boundaries, backpressure and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_fsub_norm_rnd;

    import fsub_pkg::*;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [33:0] mant;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        unf;
        logic        inexact;
    } vec_t;

    localparam int NVEC = 15;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    vec_t vecs [NVEC];

    fsub_norm_rnd_if bus ();

    fsub_norm_rnd dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [35:0] outWord();
        return {bus.o_result, bus.o_zero, bus.o_ovf, bus.o_unf, bus.o_inexact};
    endfunction

    task automatic checkOutput(input string name, input vec_t v);
        check(name, 64'(outWord()), 64'({v.result, v.zero, v.ovf, v.unf, v.inexact}));
    endtask

    task automatic setInputs(input vec_t v);
        bus.i_sign = v.sign;
        bus.i_exp  = v.exp;
        bus.i_mant = v.mant;
    endtask

    // Present one beat, then count cycles until o_valid (bounded at 10).
    task automatic applyStimulus(input vec_t v, output int lat);
        setInputs(v);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int   lat;
        int   sent;
        int   recv;
        int   extra;
        logic in_x;
        logic holding;
        logic [35:0] held;

        total  = 0;
        passed = 0;

        // sign, exp, mant, result, zero, ovf, unf, inexact
        vecs[0]  = '{1'b0, 8'd127, 34'h1_0000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd127, 34'h2_0000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd127, 34'h0_0000_0400, 32'h3480_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd127, 34'h1_0000_0100, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'd127, 34'h1_0000_0300, 32'h3F80_0002, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'd127, 34'h1_FFFF_FF00, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'd127, 34'h1_0000_0180, 32'h3F80_0001, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'd127, 34'h1_0000_0000, 32'hBF80_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'd127, 34'h0_0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd254, 34'h2_0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'd1,   34'h0_8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 8'd1,   34'h0_8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'd254, 34'h1_FFFF_FF00, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'd1,   34'h1_0000_0000, 32'h0080_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'd200, 34'h0_0000_0001, 32'hD400_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with idle inputs; everything must read zero.
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        setInputs(vecs[0]);
        idle(2);
        check("reset_valid", 64'(bus.o_valid), 64'd0);
        check("reset_outputs", 64'(outWord()), 64'd0);
        check("reset_ready", 64'(bus.o_ready), 64'd1);
        rst = 1'b0;
        idle(1);

        // Directed vector table, one beat at a time.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], lat);
            check($sformatf("latency_%0d", i), 64'(lat), 64'd3);
            checkOutput($sformatf("vector_%0d", i), vecs[i]);
        end
        idle(3);
        check("drained_valid", 64'(bus.o_valid), 64'd0);

        // Five back-to-back beats with the consumer stalling for 4 cycles.
        sent    = 0;
        recv    = 0;
        holding = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
            bus.i_ready = !(cyc >= 3 && cyc < 7);
            if (sent < 5) begin
                setInputs(vecs[sent]);
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            #4;
            in_x = bus.i_valid & bus.o_ready;
            if (bus.o_valid && !bus.i_ready) begin
                check("bp_ready_low", 64'(bus.o_ready), 64'd0);
                if (holding) begin
                    check("bp_hold", 64'(outWord()), 64'(held));
                end
                held    = outWord();
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (bus.o_valid && bus.i_ready) begin
                checkOutput($sformatf("bp_beat_%0d", recv), vecs[recv]);
                recv++;
            end
            @(posedge clk); #1;
            if (in_x) sent++;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        check("bp_count", 64'(recv), 64'd5);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            #4;
            if (bus.o_valid) extra++;
            @(posedge clk); #1;
        end
        check("bp_no_dup", 64'(extra), 64'd0);

        // Reset with two beats in flight; neither may emerge.
        setInputs(vecs[1]);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        setInputs(vecs[2]);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_flush_valid", 64'(bus.o_valid), 64'd0);
        check("rst_flush_outputs", 64'(outWord()), 64'd0);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.o_valid) extra++;
            @(posedge clk); #1;
        end
        check("rst_no_emerge", 64'(extra), 64'd0);
        applyStimulus(vecs[7], lat);
        check("rst_after_latency", 64'(lat), 64'd3);
        checkOutput("rst_after_beat", vecs[7]);
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
